// File: rtl/cam_frame_gate_if.sv
// Camera video stream bundle: frame-start pulse, line valid and pixel data.
// The producer drives through master; the consumer samples through slave.
interface cam_frame_gate_if #(
    parameter int unsigned W_D = 24
);
    logic           vsync;
    logic           href;
    logic [W_D-1:0] data;

    modport master (output vsync, href, data);
    modport slave  (input  vsync, href, data);
endinterface

// File: rtl/cam_frame_gate.sv
// Frame-admission gate between capture and encoder. It measures frame geometry,
// locks on a matching size and forwards only whole frames while locked, enabled and the encoder is idle.
module cam_frame_gate #(
    parameter int unsigned W_D         = 24,
    parameter int unsigned W_PW        = 12,
    parameter int unsigned W_PH        = 12,
    parameter int unsigned LOCK_FRAMES = 2,
    parameter int unsigned W_TO        = 24
) (
    input  logic                cam_clk,
    input  logic                rstn,
    input  logic                enable_i,
    input  logic                enc_busy_i,
    input  logic [W_PW-1:0]     pic_width_i,
    input  logic [W_PH-1:0]     pic_height_i,
    cam_frame_gate_if.slave     cam_if,
    cam_frame_gate_if.master    out_if,
    output logic                locked_o,
    output logic                frame_start_o,
    output logic                frame_drop_o,
    output logic                err_geom_o,
    output logic [W_PW-1:0]     meas_width_o,
    output logic [W_PH-1:0]     meas_height_o
);

    localparam int unsigned W_GC = 4;
    localparam logic [W_GC-1:0] LOCK_N   = W_GC'(LOCK_FRAMES);
    localparam logic [W_PW-1:0] PIX_MAX  = {W_PW{1'b1}};
    localparam logic [W_PH-1:0] LINE_MAX = {W_PH{1'b1}};
    localparam logic [W_TO-1:0] TO_MAX   = {W_TO{1'b1}};

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        PASS   = 2'd1,
        SKIP   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            vsync_q, hv_q, armed_q;
    logic            armed_d;
    logic [W_PW-1:0] pix_cnt_q, pix_cnt_d;
    logic [W_PH-1:0] line_cnt_q, line_cnt_d;
    logic [W_PW-1:0] first_w_q, first_w_d;
    logic            width_bad_q, width_bad_d;
    logic [W_GC-1:0] good_cnt_q, good_cnt_d;
    logic [W_TO-1:0] to_cnt_q, to_cnt_d;
    logic            locked_q, locked_d;
    logic            start_q, start_d;
    logic            drop_q, drop_d;
    logic            err_q, err_d;
    logic [W_PW-1:0] meas_w_q, meas_w_d;
    logic [W_PH-1:0] meas_h_q, meas_h_d;
    logic            ov_q, ov_d;
    logic            oh_q, oh_d;
    logic [W_D-1:0]  od_q, od_d;

    logic            hv_c, bound_c, fall_c, wd_hit_c, good_c, wbad_eff_c, pass_c;
    logic [W_PH-1:0] line_eff_c;
    logic [W_PW-1:0] first_eff_c;
    logic [W_GC-1:0] gc_c;

    // State and datapath registers
    always_ff @(posedge cam_clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= SEARCH;
            vsync_q     <= 1'b0;
            hv_q        <= 1'b0;
            armed_q     <= 1'b0;
            pix_cnt_q   <= '0;
            line_cnt_q  <= '0;
            first_w_q   <= '0;
            width_bad_q <= 1'b0;
            good_cnt_q  <= '0;
            to_cnt_q    <= '0;
            locked_q    <= 1'b0;
            start_q     <= 1'b0;
            drop_q      <= 1'b0;
            err_q       <= 1'b0;
            meas_w_q    <= '0;
            meas_h_q    <= '0;
            ov_q        <= 1'b0;
            oh_q        <= 1'b0;
            od_q        <= '0;
        end else begin
            state_q     <= state_d;
            vsync_q     <= cam_if.vsync;
            hv_q        <= hv_c;
            armed_q     <= armed_d;
            pix_cnt_q   <= pix_cnt_d;
            line_cnt_q  <= line_cnt_d;
            first_w_q   <= first_w_d;
            width_bad_q <= width_bad_d;
            good_cnt_q  <= good_cnt_d;
            to_cnt_q    <= to_cnt_d;
            locked_q    <= locked_d;
            start_q     <= start_d;
            drop_q      <= drop_d;
            err_q       <= err_d;
            meas_w_q    <= meas_w_d;
            meas_h_q    <= meas_h_d;
            ov_q        <= ov_d;
            oh_q        <= oh_d;
            od_q        <= od_d;
        end
    end

    // Measurement, lock tracking, admission decision and output gating
    always_comb begin
        state_d     = state_q;
        armed_d     = armed_q;
        pix_cnt_d   = pix_cnt_q;
        line_cnt_d  = line_cnt_q;
        first_w_d   = first_w_q;
        width_bad_d = width_bad_q;
        good_cnt_d  = good_cnt_q;
        to_cnt_d    = to_cnt_q;
        locked_d    = locked_q;
        start_d     = 1'b0;
        drop_d      = 1'b0;
        err_d       = 1'b0;
        meas_w_d    = meas_w_q;
        meas_h_d    = meas_h_q;
        gc_c        = good_cnt_q;

        hv_c     = cam_if.href & ~cam_if.vsync;
        bound_c  = cam_if.vsync & ~vsync_q;
        fall_c   = hv_q & ~hv_c;
        wd_hit_c = (to_cnt_q == TO_MAX);

        // Frame view including a line that closes in this very cycle
        line_eff_c  = (fall_c && (line_cnt_q != LINE_MAX)) ? line_cnt_q + W_PH'(1) : line_cnt_q;
        wbad_eff_c  = width_bad_q | (fall_c & (pix_cnt_q != pic_width_i));
        first_eff_c = (fall_c && (line_cnt_q == '0)) ? pix_cnt_q : first_w_q;
        good_c      = ~wbad_eff_c & (line_eff_c == pic_height_i);

        if (bound_c) begin
            pix_cnt_d   = '0;
            line_cnt_d  = '0;
            first_w_d   = '0;
            width_bad_d = 1'b0;
            to_cnt_d    = '0;
            meas_w_d    = first_eff_c;
            meas_h_d    = line_eff_c;
            armed_d     = 1'b1;
            if (armed_q) begin
                if (good_c) begin
                    gc_c = (good_cnt_q == LOCK_N) ? good_cnt_q : good_cnt_q + W_GC'(1);
                end else begin
                    gc_c  = '0;
                    err_d = 1'b1;
                end
            end
            good_cnt_d = gc_c;
            locked_d   = (gc_c == LOCK_N);
            if (locked_d && enable_i && !enc_busy_i) begin
                state_d = PASS;
                start_d = 1'b1;
            end else if (locked_d) begin
                state_d = SKIP;
                drop_d  = 1'b1;
            end else begin
                state_d = SEARCH;
            end
        end else begin
            to_cnt_d = wd_hit_c ? to_cnt_q : to_cnt_q + W_TO'(1);
            if (fall_c) begin
                line_cnt_d  = line_eff_c;
                width_bad_d = wbad_eff_c;
                first_w_d   = first_eff_c;
                pix_cnt_d   = '0;
            end else if (hv_c && (pix_cnt_q != PIX_MAX)) begin
                pix_cnt_d = pix_cnt_q + W_PW'(1);
            end
            // Lost vsync: drop lock and truncate whatever is being forwarded
            if (wd_hit_c) begin
                locked_d   = 1'b0;
                good_cnt_d = '0;
                armed_d    = 1'b0;
                state_d    = SEARCH;
            end
        end

        pass_c = (state_d == PASS);
        ov_d   = pass_c & cam_if.vsync;
        oh_d   = pass_c & cam_if.href;
        od_d   = (pass_c && cam_if.href) ? cam_if.data : '0;
    end

    assign out_if.vsync  = ov_q;
    assign out_if.href   = oh_q;
    assign out_if.data   = od_q;
    assign locked_o      = locked_q;
    assign frame_start_o = start_q;
    assign frame_drop_o  = drop_q;
    assign err_geom_o    = err_q;
    assign meas_width_o  = meas_w_q;
    assign meas_height_o = meas_h_q;

endmodule

// File: tb/tb_cam_frame_gate.sv
// Directed bench for cam_frame_gate: lock-up, busy drop, geometry error,
// mid-frame disable, vsync watchdog and mid-frame reset on an 8x4 picture.
module tb_cam_frame_gate;

    localparam int unsigned W_D  = 24;
    localparam int unsigned W_PW = 12;
    localparam int unsigned W_PH = 12;
    localparam int unsigned LOCK = 2;
    localparam int unsigned W_TO = 6;
    localparam int PW = 8;
    localparam int PH = 4;

    logic            cam_clk = 1'b0;
    logic            rstn = 1'b0;
    logic            enable_i = 1'b1;
    logic            enc_busy_i = 1'b0;
    logic [W_PW-1:0] pic_width_i = W_PW'(PW);
    logic [W_PH-1:0] pic_height_i = W_PH'(PH);
    logic            locked_o, frame_start_o, frame_drop_o, err_geom_o;
    logic [W_PW-1:0] meas_width_o;
    logic [W_PH-1:0] meas_height_o;

    int errors = 0;
    int checks = 0;

    cam_frame_gate_if #(.W_D(W_D)) cam_vif ();
    cam_frame_gate_if #(.W_D(W_D)) out_vif ();

    cam_frame_gate #(
        .W_D(W_D), .W_PW(W_PW), .W_PH(W_PH), .LOCK_FRAMES(LOCK), .W_TO(W_TO)
    ) dut (
        .cam_clk       (cam_clk),
        .rstn          (rstn),
        .enable_i      (enable_i),
        .enc_busy_i    (enc_busy_i),
        .pic_width_i   (pic_width_i),
        .pic_height_i  (pic_height_i),
        .cam_if        (cam_vif),
        .out_if        (out_vif),
        .locked_o      (locked_o),
        .frame_start_o (frame_start_o),
        .frame_drop_o  (frame_drop_o),
        .err_geom_o    (err_geom_o),
        .meas_width_o  (meas_width_o),
        .meas_height_o (meas_height_o)
    );

    always #5 cam_clk = ~cam_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge cam_clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "/out_vsync"}, 32'(out_vif.vsync), 32'd0);
        check({tag, "/out_href"},  32'(out_vif.href),  32'd0);
        check({tag, "/out_data"},  32'(out_vif.data),  32'd0);
        check({tag, "/locked"},    32'(locked_o),      32'd0);
        check({tag, "/start"},     32'(frame_start_o), 32'd0);
        check({tag, "/drop"},      32'(frame_drop_o),  32'd0);
        check({tag, "/err"},       32'(err_geom_o),    32'd0);
        check({tag, "/meas_w"},    32'(meas_width_o),  32'd0);
        check({tag, "/meas_h"},    32'(meas_height_o), 32'd0);
    endtask

    // One frame: vsync cycle, two idle cycles, then nl lines of PW pixels plus two blank cycles.
    // Verdict pulses checked right after the vsync edge; output stream checked every cycle.
    task automatic send_frame(input string name, input int nl, input int bad_line, input int bad_w,
                              input int rst_at, input logic exp_pass, input logic exp_drop,
                              input logic exp_err, input logic exp_lock,
                              input int exp_mw, input int exp_mh);
        int total;
        int pos, line, col, w;
        logic vs, hr;
        logic [W_D-1:0] d;
        logic [W_D+1:0] obs_o, exp_o;
        total = 3 + nl * (PW + 2);
        for (int c = 0; c < total; c++) begin
            vs = (c == 0);
            hr = 1'b0;
            if (c >= 3) begin
                pos  = c - 3;
                line = pos / (PW + 2);
                col  = pos % (PW + 2);
                w    = (line == bad_line) ? bad_w : PW;
                hr   = (col < w);
            end
            d = W_D'($urandom);
            cam_vif.vsync = vs;
            cam_vif.href  = hr;
            cam_vif.data  = d;
            if (c == rst_at) begin
                rstn = 1'b0;
                #1;
                check_all_zero({name, "/async_rst"});
                tick();
                tick();
                cam_vif.vsync = 1'b0;
                cam_vif.href  = 1'b0;
                rstn = 1'b1;
                return;
            end
            tick();
            obs_o = {out_vif.vsync, out_vif.href, out_vif.data};
            exp_o = exp_pass ? {vs, hr, (hr ? d : W_D'(0))} : '0;
            check({name, "/stream"}, 32'(obs_o), 32'(exp_o));
            if (c == 0) begin
                check({name, "/start"},  32'(frame_start_o), 32'(exp_pass));
                check({name, "/drop"},   32'(frame_drop_o),  32'(exp_drop));
                check({name, "/err"},    32'(err_geom_o),    32'(exp_err));
                check({name, "/locked"}, 32'(locked_o),      32'(exp_lock));
                if (exp_mw >= 0) check({name, "/meas_w"}, 32'(meas_width_o),  32'(exp_mw));
                if (exp_mh >= 0) check({name, "/meas_h"}, 32'(meas_height_o), 32'(exp_mh));
            end
            if (c == 1) begin
                check({name, "/start_1cyc"}, 32'(frame_start_o), 32'd0);
                check({name, "/drop_1cyc"},  32'(frame_drop_o),  32'd0);
                check({name, "/err_1cyc"},   32'(err_geom_o),    32'd0);
            end
        end
    endtask

    initial begin
        cam_vif.vsync = 1'b0;
        cam_vif.href  = 1'b0;
        cam_vif.data  = '0;
        #1;
        check_all_zero("reset");
        tick();
        tick();
        rstn = 1'b1;
        tick();

        // Lock-up: first boundary only arms, second gives one good frame, third locks
        //         name   nl  bl  bw  rst pass drop err lock mw  mh
        send_frame("f1",  PH, -1, 0,  -1, 0,   0,   0,  0,   0,  0);
        send_frame("f2",  PH, -1, 0,  -1, 0,   0,   0,  0,   PW, PH);
        send_frame("f3",  PH, -1, 0,  -1, 1,   0,   0,  1,   PW, PH);
        send_frame("f4",  PH, -1, 0,  -1, 1,   0,   0,  1,   PW, PH);

        // Encoder busy at the boundary drops the whole frame; clearing it mid-frame frees the next one
        enc_busy_i = 1'b1;
        fork
            send_frame("f5_busy", PH, -1, 0, -1, 0, 1, 0, 1, PW, PH);
            begin
                repeat (20) @(posedge cam_clk);
                #2 enc_busy_i = 1'b0;
            end
        join
        send_frame("f6",  PH, -1, 0,  -1, 1,   0,   0,  1,   PW, PH);

        // Short second line breaks lock; two good frames rebuild it
        send_frame("f7_bad", PH, 1, PW - 1, -1, 1, 0, 0, 1, PW, PH);
        send_frame("f8",  PH, -1, 0,  -1, 0,   0,   1,  0,   PW, PH);
        send_frame("f9",  PH, -1, 0,  -1, 0,   0,   0,  0,   PW, PH);

        // Disable mid-frame: current frame stays intact, next one is dropped
        fork
            send_frame("f10_dis", PH, -1, 0, -1, 1, 0, 0, 1, PW, PH);
            begin
                repeat (20) @(posedge cam_clk);
                #2 enable_i = 1'b0;
            end
        join
        send_frame("f11", PH, -1, 0,  -1, 0,   1,   0,  1,   PW, PH);
        enable_i = 1'b1;
        send_frame("f12", PH, -1, 0,  -1, 1,   0,   0,  1,   PW, PH);

        // Vsync stops while forwarding: watchdog truncates the stream and drops lock
        cam_vif.href = 1'b1;
        repeat (5) tick();
        check("wd/pre_href",   32'(out_vif.href), 32'd1);
        check("wd/pre_locked", 32'(locked_o),     32'd1);
        repeat (25) tick();
        check("wd/href",   32'(out_vif.href), 32'd0);
        check("wd/data",   32'(out_vif.data), 32'd0);
        check("wd/locked", 32'(locked_o),     32'd0);
        cam_vif.href = 1'b0;
        send_frame("f13", PH, -1, 0,  -1, 0,   0,   0,  0,   -1, -1);
        send_frame("f14", PH, -1, 0,  -1, 0,   0,   0,  0,   PW, PH);

        // Reset mid-line while forwarding, then re-acquire from scratch
        send_frame("f15_rst", PH, -1, 0, 15, 1, 0, 0, 1, PW, PH);
        send_frame("f16", PH, -1, 0,  -1, 0,   0,   0,  0,   -1, -1);
        send_frame("f17", PH, -1, 0,  -1, 0,   0,   0,  0,   PW, PH);
        send_frame("f18", PH, -1, 0,  -1, 1,   0,   0,  1,   PW, PH);
        send_frame("f19", PH, -1, 0,  -1, 1,   0,   0,  1,   PW, PH);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
